intc_vec: RTL and testbench

- Parametrised machine-mode trap controller, successor to the single-source interrupt handler. Sits between ID/EX and the CSR file.
- Accepts NUM_IRQ external interrupt lines with per-line mask and edge/level mode, plus synchronous ECALL/EBREAK exceptions.
- Sequences mepc/mstatus/mcause writes, stalls the pipeline, then issues a redirect in direct or vectored mtvec mode. Handles MRET.

---
 rtl/intc_vec.sv | 177 +++++++++++++++++
 tb/tb_intc_vec.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_vec.sv
// Machine-mode trap controller: prioritises ECALL/EBREAK, masked IRQs and MRET, then sequences mepc/mstatus/mcause writes and a redirect.
// A request is taken in an IDLE cycle; a trap redirects 4 cycles later and MRET 2 cycles later, with hold_o stalling the pipeline throughout.
module intc_vec #(
    parameter int          NUM_IRQ     = 8,
    parameter logic [15:0] EDGE_MASK   = 16'h0000,
    parameter int          SYNC_STAGES = 2,
    parameter int          CAUSE_BASE  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    output logic               csr_we_o,
    output logic [11:0]        csr_addr_o,
    output logic [31:0]        csr_data_o,
    output logic               hold_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic [NUM_IRQ-1:0] irq_pending_o
);
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [NUM_IRQ-1:0] EDGE_SEL = EDGE_MASK[NUM_IRQ-1:0];

    typedef enum logic [2:0] {
        S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_JUMP, S_MRET_MSTATUS, S_MRET_JUMP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_IRQ-1:0] w_irq_sync, w_rise, w_pending, w_irq_hit, w_ack;
    logic [NUM_IRQ-1:0] r_irq_prev, r_pend_edge;
    logic [3:0]         w_win_idx, r_idx;
    logic               w_is_exc, w_is_irq, w_is_mret, w_take;
    logic [4:0]         w_exc_code, w_irq_code, r_code;
    logic [31:0]        w_base, w_vec_tgt, r_mepc_val, r_target;
    logic               r_cause_irq;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_irq_sync = irq_i & {NUM_IRQ{rst_n}};
        end else begin : g_sync
            logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= irq_i;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_irq_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // A new edge in the same cycle as its ack keeps the line pending.
    assign w_rise    = w_irq_sync & ~r_irq_prev;
    assign w_pending = (EDGE_SEL & r_pend_edge) | (~EDGE_SEL & w_irq_sync);
    assign irq_pending_o = w_pending;
    assign irq_ack_o     = w_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_prev  <= '0;
            r_pend_edge <= '0;
        end else begin
            r_irq_prev  <= w_irq_sync;
            r_pend_edge <= EDGE_SEL & (w_rise | (r_pend_edge & ~w_ack));
        end
    end

    assign w_irq_hit = w_pending & irq_en_i;
    always_comb begin
        w_win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_irq_hit[i]) w_win_idx = 4'(i);
        end
    end

    assign w_is_exc   = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
    assign w_is_irq   = csr_mstatus[3] & (|w_irq_hit);
    assign w_is_mret  = (inst_i == INST_MRET);
    assign w_take     = rst_n & (r_state == S_IDLE) & (w_is_exc | w_is_irq | w_is_mret);
    assign w_exc_code = (inst_i == INST_ECALL) ? 5'd11 : 5'd3;
    assign w_irq_code = 5'(CAUSE_BASE) + 5'(w_win_idx);
    assign w_base     = {csr_mtvec[31:2], 2'b00};
    assign w_vec_tgt  = w_base + {25'd0, w_irq_code, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cause_irq <= 1'b0;
            r_code      <= '0;
            r_idx       <= '0;
            r_mepc_val  <= '0;
            r_target    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_mepc_val <= inst_addr_i;
                r_idx      <= w_win_idx;
                if (w_is_exc) begin
                    r_cause_irq <= 1'b0;
                    r_code      <= w_exc_code;
                    r_target    <= w_base;
                end else begin
                    r_cause_irq <= w_is_irq;
                    r_code      <= w_irq_code;
                    r_target    <= (csr_mtvec[1:0] == 2'b01) ? w_vec_tgt : w_base;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take && (w_is_exc || w_is_irq)) w_state_nxt = S_MEPC;
                else if (w_take)                      w_state_nxt = S_MRET_MSTATUS;
            end
            S_MEPC:         w_state_nxt = S_MSTATUS;
            S_MSTATUS:      w_state_nxt = S_MCAUSE;
            S_MCAUSE:       w_state_nxt = S_JUMP;
            S_MRET_MSTATUS: w_state_nxt = S_MRET_JUMP;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        csr_we_o     = 1'b0;
        csr_addr_o   = '0;
        csr_data_o   = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        w_ack        = '0;
        hold_o       = (r_state != S_IDLE) | w_take;
        case (r_state)
            S_MEPC: begin
                csr_we_o   = 1'b1;
                csr_addr_o = 12'h341;
                csr_data_o = r_mepc_val;
            end
            S_MSTATUS: begin
                csr_we_o   = 1'b1;
                csr_addr_o = 12'h300;
                csr_data_o = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4], 1'b0, csr_mstatus[2:0]};
            end
            S_MCAUSE: begin
                csr_we_o   = 1'b1;
                csr_addr_o = 12'h342;
                csr_data_o = {r_cause_irq, 26'd0, r_code};
                w_ack      = r_cause_irq ? (NUM_IRQ'(1) << r_idx) : '0;
            end
            S_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = r_target;
            end
            S_MRET_MSTATUS: begin
                csr_we_o   = 1'b1;
                csr_addr_o = 12'h300;
                csr_data_o = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4], csr_mstatus[7], csr_mstatus[2:0]};
            end
            S_MRET_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_intc_vec.sv
// Bench for intc_vec: directed scenarios with literal expectations plus randomized traffic checked every cycle against a queue-based model.
module tb_intc_vec;
    localparam int          N    = 8;
    localparam int          CB   = 16;
    localparam logic [7:0]  EDGE = 8'h44;
    localparam logic [31:0] NOP = 32'h0000_0013, ECALL = 32'h0000_0073,
                            EBREAK = 32'h0010_0073, MRET = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  irq_i = '0, irq_en_i = '0;
    logic [31:0] inst_i = NOP, inst_addr_i = '0, csr_mtvec = '0, csr_mepc = '0, csr_mstatus = '0;
    logic        csr_we_o, hold_o, int_assert_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_data_o, int_addr_o;
    logic [7:0]  irq_ack_o, irq_pending_o;

    intc_vec #(.NUM_IRQ(N), .EDGE_MASK(16'h0044), .SYNC_STAGES(2), .CAUSE_BASE(CB)) dut (
        .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_en_i(irq_en_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .csr_mstatus(csr_mstatus), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
        .csr_data_o(csr_data_o), .hold_o(hold_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o), .irq_ack_o(irq_ack_o), .irq_pending_o(irq_pending_o));

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // kind: 0 fixed data, 1 trap mstatus, 2 mret mstatus, 3 mret jump (target = live mepc)
    typedef struct {
        bit we; logic [11:0] addr; int kind; logic [31:0] data;
        bit as; logic [31:0] ia; logic [7:0] ack;
    } step_t;
    step_t       q[$];
    logic [7:0]  hist0 = '0, hist1 = '0, prev = '0, pend_e = '0, m_ack;
    int          m_kind, m_idx;

    function automatic logic [7:0] m_pending();
        return (EDGE & pend_e) | (~EDGE & hist1);
    endfunction

    // kind: 0 none, 1 exception, 2 interrupt, 3 mret
    task automatic m_decide(output int kind, output int idx);
        logic [7:0] hit;
        kind = 0; idx = 0;
        hit = m_pending() & irq_en_i;
        if (!rst_n) kind = 0;
        else if (inst_i == ECALL || inst_i == EBREAK) kind = 1;
        else if (csr_mstatus[3] && hit != 0) begin
            kind = 2;
            for (int i = N - 1; i >= 0; i--) if (hit[i]) idx = i;
        end else if (inst_i == MRET) kind = 3;
    endtask

    task automatic m_push(input int kind, input int idx);
        logic [31:0] base, tgt, cause;
        logic [4:0]  code;
        logic [7:0]  ack;
        base = csr_mtvec & 32'hFFFF_FFFC;
        if (kind == 3) begin
            q.push_back('{1, 12'h300, 2, 0, 0, 0, 0});
            q.push_back('{0, 0, 3, 0, 1, 0, 0});
        end else begin
            if (kind == 1) begin
                code = (inst_i == ECALL) ? 5'd11 : 5'd3;
                cause = {27'd0, code}; tgt = base; ack = 0;
            end else begin
                code = 5'(CB + idx);
                cause = 32'h8000_0000 | {27'd0, code};
                tgt = (csr_mtvec[1:0] == 2'b01) ? base + 4 * {27'd0, code} : base;
                ack = 8'(1 << idx);
            end
            q.push_back('{1, 12'h341, 0, inst_addr_i, 0, 0, 0});
            q.push_back('{1, 12'h300, 1, 0, 0, 0, 0});
            q.push_back('{1, 12'h342, 0, cause, 0, 0, ack});
            q.push_back('{0, 0, 0, 0, 1, tgt, 0});
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete(); hist0 = 0; hist1 = 0; prev = 0; pend_e = 0;
        end else begin
            m_ack = (q.size() != 0) ? q[0].ack : 8'h00;
            if (q.size() == 0) begin
                m_decide(m_kind, m_idx);
                if (m_kind != 0) m_push(m_kind, m_idx);
            end else begin
                void'(q.pop_front());
            end
            pend_e = EDGE & ((pend_e & ~m_ack) | (hist1 & ~prev));
            prev = hist1; hist1 = hist0; hist0 = irq_i;
        end
    end

    // ---------------- per-cycle compare ----------------
    step_t       e;
    logic [31:0] e_data, e_ia;
    int          c_kind, c_idx;
    initial begin
        #3;
        forever begin
            @(negedge clk);
            e = (q.size() != 0) ? q[0] : '{0, 0, 0, 0, 0, 0, 0};
            e_data = e.data; e_ia = e.ia;
            if (e.kind == 1) begin e_data = csr_mstatus; e_data[7] = csr_mstatus[3]; e_data[3] = 1'b0; end
            if (e.kind == 2) begin e_data = csr_mstatus; e_data[3] = csr_mstatus[7]; e_data[7] = 1'b1; end
            if (e.kind == 3) e_ia = csr_mepc;
            m_decide(c_kind, c_idx);
            chk("cyc_we",      32'(csr_we_o),      32'(e.we));
            chk("cyc_addr",    32'(csr_addr_o),    32'(e.addr));
            chk("cyc_data",    csr_data_o,         e_data);
            chk("cyc_assert",  32'(int_assert_o),  32'(e.as));
            chk("cyc_iaddr",   int_addr_o,         e_ia);
            chk("cyc_ack",     32'(irq_ack_o),     32'(e.ack));
            chk("cyc_hold",    32'(hold_o),        32'((q.size() != 0) || (c_kind != 0)));
            chk("cyc_pending", 32'(irq_pending_o), 32'(m_pending()));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic grab(output logic [31:0] mepc_w, output logic [31:0] mst_w,
                        output logic [31:0] cause_w, output logic [7:0] ack_w,
                        output logic [31:0] tgt);
        bit done = 0;
        mepc_w = 0; mst_w = 0; cause_w = 0; ack_w = 0; tgt = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (csr_we_o && csr_addr_o == 12'h341) mepc_w = csr_data_o;
            if (csr_we_o && csr_addr_o == 12'h300) mst_w = csr_data_o;
            if (csr_we_o && csr_addr_o == 12'h342) begin cause_w = csr_data_o; ack_w = irq_ack_o; end
            if (int_assert_o) begin tgt = int_addr_o; done = 1; end
        end
        chk("grab_redirect_seen", 32'(done), 32'd1);
    endtask

    logic [31:0] g_mepc, g_mst, g_cause, g_tgt, rnd;
    logic [7:0]  g_ack;
    bit          found;

    initial begin
        #2 rst_n = 1'b0;
        tick(3);
        chk("rst_hold", 32'(hold_o), 0);
        chk("rst_we", 32'(csr_we_o), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_hold", 32'(hold_o), 0);
            chk("idle_assert", 32'(int_assert_o), 0);
        end
        tick(1);

        // Level line 5, direct mode
        csr_mstatus = 32'h8; irq_en_i = 8'hFF; inst_addr_i = 32'h100;
        csr_mtvec = 32'h8000_0000; irq_i = 8'h20;
        grab(g_mepc, g_mst, g_cause, g_ack, g_tgt);
        chk("l5_mepc", g_mepc, 32'h100);
        chk("l5_mstatus", g_mst, 32'h80);
        chk("l5_mcause", g_cause, 32'h8000_0015);
        chk("l5_ack", 32'(g_ack), 32'h20);
        chk("l5_target", g_tgt, 32'h8000_0000);
        tick(1); irq_i = 0; tick(14);

        // Same, vectored
        csr_mtvec = 32'h8000_0001; irq_i = 8'h20;
        grab(g_mepc, g_mst, g_cause, g_ack, g_tgt);
        chk("vec_target", g_tgt, 32'h8000_0054);
        tick(1); irq_i = 0; tick(14);

        // Edge lines 2 and 6 pulsed together
        csr_mtvec = 32'h8000_0000; irq_i = 8'h44;
        tick(1); irq_i = 0;
        grab(g_mepc, g_mst, g_cause, g_ack, g_tgt);
        chk("edge_first_cause", g_cause, 32'h8000_0012);
        chk("edge_first_ack", 32'(g_ack), 32'h04);
        grab(g_mepc, g_mst, g_cause, g_ack, g_tgt);
        chk("edge_second_cause", g_cause, 32'h8000_0016);
        chk("edge_second_ack", 32'(g_ack), 32'h40);
        tick(12);
        chk("edge_cleared", 32'(irq_pending_o), 0);

        // ECALL / EBREAK ignore MIE and vectoring
        csr_mstatus = 32'h0; csr_mtvec = 32'h8000_0001; irq_i = 8'h01; inst_i = ECALL;
        grab(g_mepc, g_mst, g_cause, g_ack, g_tgt);
        chk("ecall_cause", g_cause, 32'h0000_000B);
        chk("ecall_target", g_tgt, 32'h8000_0000);
        chk("ecall_ack", 32'(g_ack), 0);
        tick(1); inst_i = NOP; tick(10);
        inst_i = EBREAK;
        grab(g_mepc, g_mst, g_cause, g_ack, g_tgt);
        chk("ebreak_cause", g_cause, 32'h0000_0003);
        tick(1); inst_i = NOP; irq_i = 0; tick(10);

        // MRET
        csr_mstatus = 32'h80; csr_mepc = 32'h200; inst_i = MRET;
        grab(g_mepc, g_mst, g_cause, g_ack, g_tgt);
        chk("mret_mstatus", g_mst, 32'h88);
        chk("mret_target", g_tgt, 32'h200);
        tick(1); inst_i = NOP; tick(10);

        // Reset during c1 of a trap
        csr_mstatus = 32'h0; inst_i = ECALL; found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = csr_we_o && csr_addr_o == 12'h341;
        end
        chk("c1_reached", 32'(found), 1);
        #1 rst_n = 1'b0; inst_i = NOP;
        #1;
        chk("abort_we", 32'(csr_we_o), 0);
        chk("abort_data", csr_data_o, 0);
        chk("abort_hold", 32'(hold_o), 0);
        chk("abort_assert", 32'(int_assert_o), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_redirect", 32'(int_assert_o), 0);
        end
        tick(1); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_abort_no_redirect", 32'(int_assert_o), 0);
        end
        tick(1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) irq_i = 8'($urandom);
            if ($urandom_range(0, 15) == 0) irq_en_i = 8'($urandom);
            if ($urandom_range(0, 7) == 0) csr_mstatus = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                rnd = $urandom;
                csr_mtvec = {rnd[31:2], ($urandom_range(0, 1) == 1) ? 2'b01 : rnd[1:0]};
            end
            csr_mepc = $urandom; inst_addr_i = $urandom;
            case ($urandom_range(0, 11))
                0: inst_i = ECALL;
                1: inst_i = EBREAK;
                2, 3: inst_i = MRET;
                4: inst_i = $urandom;
                default: inst_i = NOP;
            endcase
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
        $fatal(1, "watchdog");
    end
endmodule
